// File: rtl/ice40_pll_ctrl_pkg.sv
// Shared types and helpers for the iCE40 PLL sequencing controller.
package ice40_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    FILTER,
    RUN,
    BYPASS
  } state_e;

  localparam int DEF_RESET_CYCLES = 16;
  localparam int DEF_LOCK_FILTER  = 64;
  localparam int DEF_TIMEOUT      = 4096;
  localparam int DEF_NUM_DOMAINS  = 2;
  localparam int DEF_STAGGER      = 8;
  localparam int DEF_CNT_W        = 16;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ice40_lock_filter.sv
// Two-flop synchroniser for PLL LOCK plus a consecutive-high counter that
// qualifies the synchronised lock before the controller trusts it.
module ice40_lock_filter
  import ice40_pll_ctrl_pkg::*;
#(
  parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  input  logic clear,
  output logic lock_s,
  output logic lock_ok
);

  localparam int FW = cnt_width(LOCK_FILTER);

  logic          sync1;
  logic [FW-1:0] high_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source; blocking here would collapse
  // the two synchroniser stages into one.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      lock_s   <= 1'b0;
      high_cnt <= '0;
    end else begin
      sync1  <= pll_lock;
      lock_s <= sync1;
      if (clear || !lock_s) high_cnt <= '0;
      else if (high_cnt != FW'(LOCK_FILTER)) high_cnt <= high_cnt + 1'b1;
    end
  end

  // high_cnt holds the highs already seen; this cycle's high completes the run.
  assign lock_ok = lock_s && (high_cnt >= FW'(LOCK_FILTER - 1));

endmodule

// File: rtl/ice40_pll_ctrl.sv
// Sequencer for an SB_PLL40_CORE: reset/bypass control, lock qualification
// with timeout-and-retry, and staggered release of downstream resets.
module ice40_pll_ctrl
  import ice40_pll_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int LOCK_FILTER  = DEF_LOCK_FILTER,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int NUM_DOMAINS  = DEF_NUM_DOMAINS,
  parameter int STAGGER      = DEF_STAGGER,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_lock,
  input  logic                   bypass_req,
  output logic                   pll_resetb,
  output logic                   pll_bypass,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   locked,
  output logic                   err_timeout,
  output logic [CNT_W-1:0]       lost_count
);

  // Release counter saturates one past the last release so locked can follow it.
  localparam int REL_MAX = (NUM_DOMAINS - 1) * STAGGER + 1;
  localparam int RW      = cnt_width(REL_MAX);
  localparam int RCW     = cnt_width(RESET_CYCLES);
  localparam int TW      = cnt_width(TIMEOUT);

  state_e                 state, state_nx;
  logic [RCW-1:0]         rst_cnt, rst_cnt_nx;
  logic [TW-1:0]          to_cnt, to_cnt_nx;
  logic [RW-1:0]          rel_cnt, rel_cnt_nx;
  logic [NUM_DOMAINS-1:0] rst_out_nx;
  logic                   locked_nx, resetb_nx, bypass_nx;
  logic                   lock_s, lock_ok, filt_clear;
  logic                   timeout, lost, stay, waiting, waiting_nx, releasing;

  assign filt_clear = !(state == WAIT_LOCK || state == FILTER);

  ice40_lock_filter #(
    .LOCK_FILTER(LOCK_FILTER)
  ) u_lock_filter (
    .clk     (clk),
    .reset   (reset),
    .pll_lock(pll_lock),
    .clear   (filt_clear),
    .lock_s  (lock_s),
    .lock_ok (lock_ok)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    timeout  = 1'b0;
    lost     = 1'b0;
    if (bypass_req) begin
      state_nx = BYPASS;
    end else begin
      case (state)
        RESET_PLL: if (rst_cnt == RCW'(RESET_CYCLES - 1)) state_nx = WAIT_LOCK;
        WAIT_LOCK, FILTER: begin
          if (to_cnt == TW'(TIMEOUT - 1)) begin
            timeout  = 1'b1;
            state_nx = RESET_PLL;
          end else if (state == WAIT_LOCK) begin
            if (lock_s) state_nx = FILTER;
          end else if (!lock_s) begin
            state_nx = WAIT_LOCK;
          end else if (lock_ok) begin
            state_nx = RUN;
          end
        end
        RUN: begin
          if (!lock_s) begin
            lost     = 1'b1;
            state_nx = RESET_PLL;
          end
        end
        default: state_nx = RESET_PLL;
      endcase
    end
  end

  // Counters and registered outputs are all derived from the next state.
  always_comb begin
    stay       = (state_nx == state);
    waiting    = (state == WAIT_LOCK) || (state == FILTER);
    waiting_nx = (state_nx == WAIT_LOCK) || (state_nx == FILTER);
    releasing  = (state_nx == RUN) || (state_nx == BYPASS);

    rst_cnt_nx = (stay && state == RESET_PLL) ? rst_cnt + 1'b1 : '0;
    to_cnt_nx  = (waiting && waiting_nx) ? to_cnt + 1'b1 : '0;
    rel_cnt_nx = '0;
    if (stay && (state == RUN || state == BYPASS))
      rel_cnt_nx = (rel_cnt == RW'(REL_MAX)) ? rel_cnt : rel_cnt + 1'b1;

    rst_out_nx = '1;
    for (int i = 0; i < NUM_DOMAINS; i++)
      rst_out_nx[i] = !(releasing && (rel_cnt_nx >= RW'(i * STAGGER)));

    locked_nx = (state_nx == RUN) && (rel_cnt_nx == RW'(REL_MAX));
    resetb_nx = waiting_nx || (state_nx == RUN);
    bypass_nx = (state_nx == BYPASS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RESET_PLL;
      rst_cnt     <= '0;
      to_cnt      <= '0;
      rel_cnt     <= '0;
      pll_resetb  <= 1'b0;
      pll_bypass  <= 1'b0;
      rst_out     <= '1;
      locked      <= 1'b0;
      err_timeout <= 1'b0;
      lost_count  <= '0;
    end else begin
      state      <= state_nx;
      rst_cnt    <= rst_cnt_nx;
      to_cnt     <= to_cnt_nx;
      rel_cnt    <= rel_cnt_nx;
      pll_resetb <= resetb_nx;
      pll_bypass <= bypass_nx;
      rst_out    <= rst_out_nx;
      locked     <= locked_nx;
      if (timeout) err_timeout <= 1'b1;
      if (lost && lost_count != '1) lost_count <= lost_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ice40_pll_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomised soak, all compared every cycle against a behavioural model.
module tb_ice40_pll_ctrl;

  localparam int RC = 4, LF = 8, TO = 32, ND = 3, ST = 2, CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pll_lock = 1'b0;
  logic          bypass_req = 1'b0;
  logic          pll_resetb, pll_bypass, locked, err_timeout;
  logic [ND-1:0] rst_out;
  logic [CW-1:0] lost_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ice40_pll_ctrl #(
    .RESET_CYCLES(RC), .LOCK_FILTER(LF), .TIMEOUT(TO),
    .NUM_DOMAINS(ND), .STAGGER(ST), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .bypass_req (bypass_req),
    .pll_resetb (pll_resetb),
    .pll_bypass (pll_bypass),
    .rst_out    (rst_out),
    .locked     (locked),
    .err_timeout(err_timeout),
    .lost_count (lost_count)
  );

  // ---------------- behavioural model ----------------
  typedef enum {PH_RST, PH_WAIT, PH_FILT, PH_RUN, PH_BYP} phase_e;
  phase_e        ph = PH_RST;
  int            age, wait_cycles, highs, m_cyc, m_lost;
  bit            m_valid = 1'b0, m_err, sy1, sy2;
  bit            e_resetb, e_bypass, e_locked;
  logic [ND-1:0] e_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  // Advances the model across the next rising edge using the inputs that
  // edge will sample; e_* then describe the DUT after that edge.
  task model_step();
    bit ls;
    ls  = sy2;
    sy2 = sy1;
    sy1 = pll_lock;
    if (reset) begin
      ph = PH_RST; age = 0; wait_cycles = 0; highs = 0;
      m_err = 1'b0; m_lost = 0; sy1 = 1'b0; sy2 = 1'b0; m_cyc = 0; m_valid = 1'b1;
    end else begin
      m_cyc++;
      if (bypass_req) begin
        if (ph != PH_BYP) begin ph = PH_BYP; age = 0; end
        else age++;
      end else if (ph == PH_BYP) begin
        ph = PH_RST; age = 0;
      end else if (ph == PH_RST) begin
        age++;
        if (age == RC) begin ph = PH_WAIT; wait_cycles = 0; highs = 0; end
      end else if (ph == PH_WAIT || ph == PH_FILT) begin
        wait_cycles++;
        highs = ls ? highs + 1 : 0;
        if (wait_cycles == TO) begin m_err = 1'b1; ph = PH_RST; age = 0; end
        else if (ph == PH_WAIT) begin if (ls) ph = PH_FILT; end
        else if (!ls) ph = PH_WAIT;
        else if (highs >= LF) begin ph = PH_RUN; age = 0; end
      end else begin
        if (!ls) begin
          if (m_lost < (1 << CW) - 1) m_lost++;
          ph = PH_RST; age = 0;
        end else age++;
      end
    end
    for (int i = 0; i < ND; i++)
      e_rst[i] = !((ph == PH_RUN || ph == PH_BYP) && age >= i * ST);
    e_locked = (ph == PH_RUN) && (age > (ND - 1) * ST);
    e_resetb = (ph == PH_WAIT) || (ph == PH_FILT) || (ph == PH_RUN);
    e_bypass = (ph == PH_BYP);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp pll_resetb", pll_resetb, e_resetb);
      check("cmp pll_bypass", pll_bypass, e_bypass);
      check("cmp rst_out", rst_out, e_rst);
      check("cmp locked", locked, e_locked);
      check("cmp err_timeout", err_timeout, m_err);
      check("cmp lost_count", lost_count, m_lost);
    end
    model_step();
  end

  // ---------------- stimulus ----------------
  int lock_mode = 0;   // 0: held low, 1: locks as soon as RESETB is high, 2: random PLL
  int low_left = 0, pll_age = 0, lock_delay = 0;

  task apply_lock();
    if (low_left > 0) begin
      pll_lock = 1'b0;
      low_left--;
    end else if (lock_mode == 0) begin
      pll_lock = 1'b0;
    end else if (lock_mode == 1) begin
      pll_lock = e_resetb;
    end else begin
      if (!e_resetb) begin
        pll_age = 0;
        lock_delay = $urandom_range(0, 45);
      end else pll_age++;
      pll_lock = e_resetb && (pll_age >= lock_delay);
      if (pll_lock && $urandom_range(0, 99) == 0) low_left = $urandom_range(0, 3);
    end
  endtask

  task tick();
    @(posedge clk);
    #1;
    apply_lock();
  endtask

  task do_reset();
    lock_mode = 0; low_left = 0; bypass_req = 1'b0; pll_lock = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task run_to(input int c);
    int budget;
    budget = 0;
    while (m_cyc < c && budget < 5000) begin
      tick();
      budget++;
    end
    if (m_cyc < c) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_to: reached cycle %0d required %0d", m_cyc, c);
    end
  endtask

  initial begin
    int cur;

    // Clean lock-up sequence.
    do_reset(); lock_mode = 1; apply_lock();
    run_to(3);  check("p1 resetb@3", pll_resetb, 1'b0);
    run_to(4);  check("p1 resetb@4", pll_resetb, 1'b1);
    run_to(13); check("p1 rst@13", rst_out, 3'b111);
    run_to(14); check("p1 rst@14", rst_out, 3'b110);
    run_to(16); check("p1 rst@16", rst_out, 3'b100);
    run_to(18); check("p1 rst@18", rst_out, 3'b000);
    check("p1 locked@18", locked, 1'b0);
    run_to(19); check("p1 locked@19", locked, 1'b1);

    // Lock never arrives: timeout and retry every 36 cycles.
    do_reset(); apply_lock();
    run_to(35); check("p2 err@35", err_timeout, 1'b0);
    run_to(36); check("p2 err@36", err_timeout, 1'b1);
    check("p2 resetb@36", pll_resetb, 1'b0);
    run_to(39); check("p2 resetb@39", pll_resetb, 1'b0);
    run_to(40); check("p2 resetb@40", pll_resetb, 1'b1);
    run_to(71); check("p2 resetb@71", pll_resetb, 1'b1);
    run_to(72); check("p2 resetb@72", pll_resetb, 1'b0);
    run_to(76); check("p2 resetb@76", pll_resetb, 1'b1);

    // Lock loss in RUN.
    do_reset(); lock_mode = 1; apply_lock();
    run_to(30); pll_lock = 1'b0; low_left = 2;
    run_to(32); check("p3 locked@32", locked, 1'b1);
    run_to(33); check("p3 rst@33", rst_out, 3'b111);
    check("p3 locked@33", locked, 1'b0);
    check("p3 lost@33", lost_count, 2'd1);
    run_to(60); check("p3 relocked", locked, 1'b1);

    // Single glitch while filtering restarts the filter count.
    do_reset(); lock_mode = 1; apply_lock();
    run_to(9);  pll_lock = 1'b0;
    run_to(19); check("p4 rst@19", rst_out, 3'b111);
    run_to(20); check("p4 rst@20", rst_out, 3'b110);
    run_to(25); check("p4 locked@25", locked, 1'b1);
    run_to(40); check("p4 err@40", err_timeout, 1'b0);

    // Bypass requested while waiting for lock.
    do_reset(); apply_lock();
    run_to(10); check("p5 resetb@10", pll_resetb, 1'b1);
    bypass_req = 1'b1;
    run_to(11); check("p5 bypass@11", pll_bypass, 1'b1);
    check("p5 resetb@11", pll_resetb, 1'b0);
    check("p5 rst@11", rst_out, 3'b110);
    run_to(13); check("p5 rst@13", rst_out, 3'b100);
    run_to(15); check("p5 rst@15", rst_out, 3'b000);
    check("p5 locked@15", locked, 1'b0);
    run_to(20); bypass_req = 1'b0;
    run_to(21); check("p5 rst@21", rst_out, 3'b111);
    check("p5 bypass@21", pll_bypass, 1'b0);
    run_to(25); check("p5 resetb@25", pll_resetb, 1'b1);

    // Timeout, then five lock losses saturate the counter, then a mid-RUN reset.
    do_reset(); apply_lock();
    run_to(36); check("p6 err@36", err_timeout, 1'b1);
    lock_mode = 1; apply_lock();
    for (int k = 0; k < 5; k++) begin
      cur = m_cyc;
      run_to(cur + 25);
      pll_lock = 1'b0; low_left = 2;
    end
    cur = m_cyc;
    run_to(cur + 30);
    check("p6 lost sat", lost_count, 2'd3);
    check("p6 locked", locked, 1'b1);
    reset = 1'b1;
    tick();
    check("p6 rst resetb", pll_resetb, 1'b0);
    check("p6 rst rst_out", rst_out, 3'b111);
    check("p6 rst locked", locked, 1'b0);
    check("p6 rst err", err_timeout, 1'b0);
    check("p6 rst lost", lost_count, 2'd0);
    reset = 1'b0;

    // Randomised soak against the model.
    lock_mode = 2;
    for (int n = 0; n < 4000; n++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 999) == 0) reset = 1'b1;
      if ($urandom_range(0, 199) == 0) bypass_req = !bypass_req;
    end
    bypass_req = 1'b0;
    reset = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ice40_pll_ctrl.md
Name: ice40_pll_ctrl

Overview:
Parametrised controller that sits beside an SB_PLL40_CORE instance and sequences it, generalising the bare PLL wrapper.
- Drives PLL RESETB and BYPASS.
- Synchronises and filters the PLL LOCK output.
- Enforces a lock timeout with automatic retry.
- Releases NUM_DOMAINS downstream resets in staggered order.
- Re-sequences on loss of lock or on a bypass-mode change.
Runs on the PLL reference clock.

Parameters:
RESET_CYCLES, 16, cycles RESETB is held low per PLL reset attempt (>=1)
LOCK_FILTER, 64, consecutive synchronised-lock-high cycles required before lock is declared (>=1)
TIMEOUT, 4096, max cycles in WAIT_LOCK+FILTER before retry (> LOCK_FILTER)
NUM_DOMAINS, 2, number of downstream reset outputs (>=1)
STAGGER, 8, cycles between successive domain reset releases (>=1)
CNT_W, 16, sticky lost-lock counter width

Ports:
clk  in  1  PLL reference clock; sole clock
reset  in  1  synchronous, active-high reset
pll_lock  in  1  PLL LOCK output (asynchronous to clk)
bypass_req  in  1  request PLL bypass mode (synchronous to clk)
pll_resetb  out  1  to PLL RESETB (active low)
pll_bypass  out  1  to PLL BYPASS
rst_out  out  NUM_DOMAINS  per-domain reset (active high)
locked  out  1  high while in RUN with all domains released
err_timeout  out  1  sticky; set on any lock timeout
lost_count  out  CNT_W  saturating count of lock-loss events in RUN

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- All outputs are registered.
- Reset values: pll_resetb=0, pll_bypass=0, rst_out=all 1s, locked=0, err_timeout=0, lost_count=0, state=RESET_PLL, all counters=0.
- lock_s is pll_lock passed through a 2-flop synchroniser, so it carries 2 cycles of latency. Synchroniser flops reset to 0.

States:
- RESET_PLL: pll_resetb=0, rst_out all 1.
  - Exit after exactly RESET_CYCLES cycles to WAIT_LOCK.
  - The first RESET_CYCLES cycle is the first cycle after reset deasserts.
  - The timeout counter clears on this exit.
- WAIT_LOCK: pll_resetb=1; the timeout counter increments every cycle.
  - lock_s=1 -> FILTER, with the filter counter cleared.
- FILTER: the timeout counter continues.
  - lock_s=0 -> WAIT_LOCK; the filter counter clears, the timeout counter is not reset.
  - LOCK_FILTER consecutive lock_s=1 cycles -> RUN.
- Timeout: in WAIT_LOCK or FILTER, when the timeout counter reaches TIMEOUT:
  - err_timeout is set to 1 (sticky until reset).
  - Next state is RESET_PLL. Retries repeat indefinitely.
- RUN: the release counter starts at 0 on entry.
  - rst_out[i] deasserts on the cycle the release counter equals i*STAGGER, and stays low.
  - locked=1 from the cycle after rst_out[NUM_DOMAINS-1] deasserts.
- Lock loss in RUN: lock_s=0 for one cycle causes, next cycle:
  - rst_out all 1, locked=0.
  - lost_count+1, saturating at 2^CNT_W-1.
  - State RESET_PLL.
- BYPASS, entered from any state when bypass_req=1:
  - pll_bypass=1, pll_resetb=0.
  - rst_out all 1 on entry, then the same staggered release as RUN.
  - locked stays 0. lock_s is ignored.
- Leaving BYPASS: bypass_req=0 -> rst_out all 1, pll_bypass=0, state RESET_PLL.
- Priority (highest first): reset > bypass_req > timeout > lock loss > normal progression.
- Simultaneous lock_s drop and timeout in FILTER: timeout wins, so err_timeout is set.
- Reset mid-sequence: all state returns to reset values on the next edge, including err_timeout and lost_count.
- NUM_DOMAINS=1: a single release on the first RUN cycle. The release counter width is derived from (NUM_DOMAINS-1)*STAGGER.

Decomposition:
- Package ice40_pll_ctrl_pkg:
  - state enum {RESET_PLL, WAIT_LOCK, FILTER, RUN, BYPASS}
  - function clog2-based counter width helper
  - default parameter constants
- Sub-module ice40_lock_filter:
  - 2-flop synchroniser plus consecutive-high counter.
  - Outputs lock_s and lock_ok (pulse when the count reaches LOCK_FILTER).
  - Has a clear input driven by the FSM.

Test Plan (RESET_CYCLES=4, LOCK_FILTER=8, TIMEOUT=32, NUM_DOMAINS=3, STAGGER=2):
1. Reset released, pll_lock=1 held -> pll_resetb rises at cycle 4; lock_s at cycle 6; RUN entered at cycle 14; rst_out[0] falls at 14, rst_out[1] at 16, rst_out[2] at 18; locked=1 at 19.
2. pll_lock held 0 -> err_timeout=1 at cycle 36; pll_resetb low again for 4 cycles, then retries; pattern repeats every 36 cycles.
3. In RUN, pll_lock pulsed low for 3 cycles -> rst_out=3'b111 and locked=0 two+one cycles after the drop; lost_count=1; full re-sequence follows.
4. In FILTER, lock glitches low once at filter count 5 -> returns to WAIT_LOCK; RUN is reached only after 8 fresh consecutive highs; err_timeout stays 0 if within 32 cycles.
5. bypass_req=1 during WAIT_LOCK -> pll_bypass=1, pll_resetb=0, rst_out released at +0/+2/+4, locked=0; deassert bypass_req -> rst_out=3'b111, RESET_PLL.
6. CNT_W=2, 5 lock-loss events -> lost_count saturates at 3. reset pulse mid-RUN -> all outputs return to reset values next cycle.
